// File: rtl/dvi_tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens and the
// receive alignment state encoding. Also used by the TX encoder.
package dvi_tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

  function automatic logic tmds_is_token(input logic [SYM_W-1:0] s);
    return (s == TOK_C00) || (s == TOK_C01) || (s == TOK_C10) || (s == TOK_C11);
  endfunction

endpackage

// File: rtl/dvi_rx_tmds_decoder_if.sv
// Per-lane bus between the deserializer / downstream pixel logic and the
// TMDS decoder. master = lane user, slave = decoder.
interface dvi_rx_tmds_decoder_if;
  import dvi_tmds_pkg::*;

  logic [SYM_W-1:0] tmds_word;
  logic [7:0]       data;
  logic [1:0]       ctrl;
  logic             de;
  logic             locked;
  logic [3:0]       bit_offset;
  logic [15:0]      relock_count;

  modport master (
    output tmds_word,
    input  data, ctrl, de, locked, bit_offset, relock_count
  );

  modport slave (
    input  tmds_word,
    output data, ctrl, de, locked, bit_offset, relock_count
  );

endinterface

// File: rtl/dvi_tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control tokens to C1:C0, otherwise the
// 8b transition-minimised payload is recovered and de is raised.
module dvi_tmds_symbol_decode
  import dvi_tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  input  logic [1:0]       ctrl_prev_i,
  output logic             de_o,
  output logic [1:0]       ctrl_o,
  output logic [7:0]       data_o
);

  logic [7:0] x;

  assign x = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];

  always_comb begin
    de_o      = 1'b1;
    ctrl_o    = ctrl_prev_i;
    data_o[0] = x[0];
    // bit 8 selects XOR (1) or XNOR (0) chaining used by the encoder
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    end
    case (sym_i)
      TOK_C00: begin de_o = 1'b0; ctrl_o = 2'b00; data_o = '0; end
      TOK_C01: begin de_o = 1'b0; ctrl_o = 2'b01; data_o = '0; end
      TOK_C10: begin de_o = 1'b0; ctrl_o = 2'b10; data_o = '0; end
      TOK_C11: begin de_o = 1'b0; ctrl_o = 2'b11; data_o = '0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/dvi_rx_tmds_decoder.sv
// DVI RX TMDS lane: word alignment by control-token search plus symbol decode.
// Optional lock-loss counter enabled by defining DVI_RX_RELOCK_CNT_EN.
module dvi_rx_tmds_decoder
  import dvi_tmds_pkg::*;
#(
  parameter int TOKEN_COUNT   = 8,
  parameter int SEARCH_CYCLES = 4096,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input logic          pixel_clock,
  input logic          reset_n,
  dvi_rx_tmds_decoder_if.slave bus
);

  localparam int CYC_MAX = (LOCK_TIMEOUT > SEARCH_CYCLES) ? LOCK_TIMEOUT : SEARCH_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX);
  localparam int TOK_W   = $clog2(TOKEN_COUNT + 1);

  localparam logic [TOK_W-1:0] TOK_LOCK    = TOK_W'(TOKEN_COUNT);
  localparam logic [CYC_W-1:0] SEARCH_LAST = CYC_W'(SEARCH_CYCLES - 1);
  localparam logic [CYC_W-1:0] LOCK_LAST   = CYC_W'(LOCK_TIMEOUT - 1);

  logic [SYM_W-1:0] new_q, old_q, sym_d, sym_q;
  tmds_state_e      state_q, state_d;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       off_q, off_d;
  logic             sym_tok;
  logic             dec_de;
  logic [1:0]       dec_ctrl;
  logic [7:0]       dec_data;
  logic [7:0]       data_q;
  logic [1:0]       ctrl_q;
  logic             de_q;

  // Older word holds the earlier bits, so offset 0 is the older word as-is.
  assign sym_d   = SYM_W'({new_q, old_q} >> off_q);
  assign sym_tok = tmds_is_token(sym_q);

  dvi_tmds_symbol_decode u_dec (
    .sym_i       (sym_q),
    .ctrl_prev_i (ctrl_q),
    .de_o        (dec_de),
    .ctrl_o      (dec_ctrl),
    .data_o      (dec_data)
  );

  always_comb begin
    state_d   = state_q;
    tok_cnt_d = tok_cnt_q;
    cyc_d     = cyc_q;
    off_d     = off_q;
    case (state_q)
      SEARCH: begin
        // a completed token run takes priority over the dwell timer
        if (tok_cnt_q == TOK_LOCK) begin
          state_d   = LOCKED;
          tok_cnt_d = '0;
          cyc_d     = '0;
        end else if (cyc_q == SEARCH_LAST) begin
          off_d     = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          tok_cnt_d = '0;
          cyc_d     = '0;
        end else begin
          cyc_d     = cyc_q + CYC_W'(1);
          tok_cnt_d = sym_tok ? tok_cnt_q + TOK_W'(1) : '0;
        end
      end
      LOCKED: begin
        if (sym_tok) begin
          cyc_d = '0;
        end else if (cyc_q == LOCK_LAST) begin
          state_d   = SEARCH;
          tok_cnt_d = '0;
          cyc_d     = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      new_q  <= '0;
      old_q  <= '0;
      sym_q  <= '0;
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else begin
      new_q  <= bus.tmds_word;
      old_q  <= new_q;
      sym_q  <= sym_d;
      data_q <= dec_data;
      ctrl_q <= dec_ctrl;
      de_q   <= dec_de & (state_d == LOCKED);
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      tok_cnt_q <= '0;
      cyc_q     <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      tok_cnt_q <= tok_cnt_d;
      cyc_q     <= cyc_d;
      off_q     <= off_d;
    end
  end

`ifdef DVI_RX_RELOCK_CNT_EN
  logic [15:0] relock_q, relock_d;

  assign relock_d = ((state_q == LOCKED) && (state_d == SEARCH) && (relock_q != 16'hFFFF))
                    ? relock_q + 16'd1 : relock_q;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) relock_q <= '0;
    else          relock_q <= relock_d;
  end

  assign bus.relock_count = relock_q;
`else
  assign bus.relock_count = '0;
`endif

  assign bus.data       = data_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.de         = de_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.bit_offset = off_q;

endmodule

// File: tb/tb_dvi_rx_tmds_decoder.sv
// Bench for dvi_rx_tmds_decoder: directed scenarios plus randomized bit-stream
// traffic, every cycle compared with a bit-stream level reference model.
module tb_dvi_rx_tmds_decoder;

  localparam int TC = 8;
  localparam int SC = 32;
  localparam int LT = 64;
  localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
`ifdef DVI_RX_RELOCK_CNT_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  logic pixel_clock = 1'b0;
  logic reset_n     = 1'b1;

  dvi_rx_tmds_decoder_if bus ();

  dvi_rx_tmds_decoder #(
    .TOKEN_COUNT   (TC),
    .SEARCH_CYCLES (SC),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #5 pixel_clock = ~pixel_clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // reference model state
  int         m_off, m_tok, m_cyc, m_relock;
  bit         m_lock;
  logic [9:0] m_sym, w1, w2;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic       m_de;
  bit         sb[$];

  function automatic logic [31:0] pack(input logic [7:0] d, input logic [1:0] c, input logic de,
                                       input logic lk, input logic [3:0] off, input logic [15:0] rc);
    return {d, c, de, lk, off, rc};
  endfunction

  function automatic int tok_ctrl(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == TOKS[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_tok = 0; m_cyc = 0; m_relock = 0; m_lock = 1'b0;
    m_sym = '0; w1 = '0; w2 = '0; m_data = '0; m_ctrl = '0; m_de = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w);
    logic [9:0] nsym;
    logic [7:0] x;
    int t;
    for (int j = 0; j < 10; j++)
      nsym[j] = (m_off + j < 10) ? w2[m_off + j] : w1[m_off + j - 10];
    t = tok_ctrl(m_sym);
    if (!m_lock) begin
      if (m_tok == TC) begin
        m_lock = 1'b1; m_tok = 0; m_cyc = 0;
      end else if (m_cyc == SC - 1) begin
        m_off = (m_off + 1) % 10; m_tok = 0; m_cyc = 0;
      end else begin
        m_cyc++;
        m_tok = (t >= 0) ? m_tok + 1 : 0;
      end
    end else begin
      if (t >= 0) m_cyc = 0;
      else if (m_cyc == LT - 1) begin
        m_lock = 1'b0; m_cyc = 0; m_tok = 0;
        if (RELOCK_EN && m_relock < 65535) m_relock++;
      end else m_cyc++;
    end
    if (t >= 0) begin
      m_data = '0; m_ctrl = 2'(t); m_de = 1'b0;
    end else begin
      x = m_sym[9] ? ~m_sym[7:0] : m_sym[7:0];
      m_data = x ^ {x[6:0], 1'b0};
      if (!m_sym[8]) m_data = m_data ^ 8'hFE;
      m_de = m_lock;
    end
    m_sym = nsym; w2 = w1; w1 = w;
  endtask

  function automatic logic [31:0] obs_all();
    return pack(bus.data, bus.ctrl, bus.de, bus.locked, bus.bit_offset, bus.relock_count);
  endfunction

  task automatic step(input logic [9:0] w);
    bus.tmds_word = w;
    @(posedge pixel_clock);
    cycle++;
    model_step(w);
    #1;
    chk("cycle_model", obs_all(), pack(m_data, m_ctrl, m_de, m_lock, 4'(m_off), 16'(m_relock)));
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", obs_all(), '0);
    repeat (3) begin
      bus.tmds_word = 10'($urandom);
      @(posedge pixel_clock);
      #1;
      chk("reset_hold", obs_all(), '0);
    end
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  task automatic stream_start(input int r, input bit rnd);
    sb.delete();
    for (int j = 0; j < r; j++) sb.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic stream_step(input logic [9:0] sym);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) sb.push_back(sym[j]);
    for (int j = 0; j < 10; j++) w[j] = sb.pop_front();
    step(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bus.tmds_word = '0;
    do_reset();

    // aligned lock then two data words
    for (int i = 0; i < 8; i++) step(10'h354);
    step(10'h100);
    step(10'h2FF);
    step(10'h354);
    chk("aligned_prelock", {31'd0, bus.locked}, 32'd0);
    chk("aligned_tok_ctrl", {29'd0, bus.de, bus.ctrl}, 32'd0);
    step(10'h354);
    chk("aligned_locked", {31'd0, bus.locked}, 32'd1);
    chk("aligned_data00", {23'd0, bus.de, bus.data}, {23'd0, 1'b1, 8'h00});
    step(10'h354);
    chk("aligned_dataFE", {23'd0, bus.de, bus.data}, {23'd0, 1'b1, 8'hFE});

    // three lock losses, each followed by relock
    for (int k = 0; k < 3; k++) begin
      repeat (LT + 8) step(10'h100);
      chk("loss_unlocked", {30'd0, bus.locked, bus.de}, 32'd0);
      chk("loss_offset", {28'd0, bus.bit_offset}, 32'd0);
      repeat (14) step(10'h354);
      chk("relocked", {31'd0, bus.locked}, 32'd1);
    end
    chk("relock_count", {16'd0, bus.relock_count}, RELOCK_EN ? 32'd3 : 32'd0);

    // reset while locked (async check inside)
    do_reset();

    // misaligned 0x0AB stream at bit phase 3
    stream_start(3, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 140) begin
      stream_step(10'h0AB);
      n++;
      seen = bus.locked;
    end
    chk("mis_lock_budget", {31'd0, seen && (n <= 3 * SC + TC + 3)}, 32'd1);
    chk("mis_offset", {28'd0, bus.bit_offset}, 32'd3);
    chk("mis_ctrl", {30'd0, bus.ctrl}, 32'd1);

    // 7 tokens, one data word, 7 tokens: no lock
    do_reset();
    repeat (7) step(10'h354);
    step(10'h100);
    repeat (7) step(10'h354);
    repeat (3) step(10'h100);
    chk("broken_run_nolock", {31'd0, bus.locked}, 32'd0);

    // token count completes on the dwell-expiry cycle
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step((i <= 20) ? 10'h100 : 10'h354);
      if (i == 31) chk("expiry_prelock", {31'd0, bus.locked}, 32'd0);
    end
    chk("expiry_lock", {27'd0, bus.locked, bus.bit_offset}, {27'd0, 1'b1, 4'd0});

    // randomized traffic at a random bit phase
    repeat (2) begin
      do_reset();
      stream_start($urandom_range(0, 9), 1'b1);
      repeat (450) begin
        if ($urandom_range(0, 3) != 0) stream_step(TOKS[$urandom_range(0, 3)]);
        else                           stream_step(10'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
